// File: rtl/bnn_conv_multi.sv
// bnn_conv_multi: binary 3x3 XNOR-popcount convolution engine that applies
// NUM_KERNELS kernels to each of a sequence of square binary images in SRAM.
// Ports: clk/reset (sync, active-high); dut_run/dut_busy/dut_error control;
// dut_sram_read_address/sram_dut_read_data input SRAM read (1-cycle latency);
// dut_sram_write_address/_data/_enable output row writes;
// dut_wmem_read_address/wmem_dut_read_data weight SRAM read (1-cycle latency).
// Optional feature macro: BNN_CONV_THRESH_PROG_EN (per-kernel threshold in
// kernel word bits 12:9); when undefined the threshold is fixed at 5.
`timescale 1ns/1ps
module bnn_conv_multi #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 12,
    parameter int NUM_KERNELS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic              dut_error,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [DATA_W-1:0] wmem_dut_read_data
);

    localparam int NW = $clog2(DATA_W + 1);
    localparam int CW = (NW > 4) ? NW : 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW,
        S_HDR,
        S_CONV,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [3:0]        k_q;
    logic [NW-1:0]     n_q;
    logic [ADDR_W-1:0] base_q, rd_addr_q, wm_addr_q, ptr_q, wr_addr_q;
    logic [8:0]        kern_w_q [NUM_KERNELS];
    logic [3:0]        kern_t_q [NUM_KERNELS];
    logic [DATA_W-1:0] win_q [3];
    logic [8:0]        win_w_q;
    logic [3:0]        win_t_q;
    logic [NW-1:0]     win_n_q;
    logic              win_vld_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_en_q, busy_q, err_q;

    logic start, ld_en, hdr_en, conv_en, busy_d;
    logic hdr_term, hdr_bad, last_row, pre_last, last_k, wload_done;
    logic [ADDR_W-1:0] next_base;
    logic [3:0]        ld_thr;
    logic [8:0]        cur_w;
    logic [3:0]        cur_t;
    logic [DATA_W+1:0] win_ext [3];
    logic [3:0]        match;
    logic [DATA_W-1:0] conv_row;
    logic              unused_in;

    assign dut_busy               = busy_q;
    assign dut_error              = err_q;
    assign dut_sram_read_address  = rd_addr_q;
    assign dut_sram_write_address = wr_addr_q;
    assign dut_sram_write_data    = wr_data_q;
    assign dut_sram_write_enable  = wr_en_q;
    assign dut_wmem_read_address  = wm_addr_q;

    assign unused_in = ^wmem_dut_read_data;

    assign hdr_term = sram_dut_read_data == DATA_W'(255);
    assign hdr_bad  = !hdr_term &&
                      (sram_dut_read_data < DATA_W'(3) ||
                       sram_dut_read_data > DATA_W'(DATA_W));
    assign last_row   = cnt_q == CW'(n_q) - CW'(1);
    assign pre_last   = cnt_q == CW'(n_q) - CW'(2);
    assign last_k     = k_q == 4'(NUM_KERNELS - 1);
    assign wload_done = cnt_q == CW'(NUM_KERNELS);
    assign next_base  = base_q + ADDR_W'(n_q) + ADDR_W'(1);

`ifdef BNN_CONV_THRESH_PROG_EN
    assign ld_thr = (wmem_dut_read_data[12:9] > 4'd9) ? 4'd9
                                                     : wmem_dut_read_data[12:9];
`else
    assign ld_thr = 4'd5;
`endif

    always_comb begin
        cur_w = '0;
        cur_t = '0;
        for (int i = 0; i < NUM_KERNELS; i++) begin
            if (k_q == 4'(i)) begin
                cur_w = kern_w_q[i];
                cur_t = kern_t_q[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (dut_run) state_d = S_LOADW;
            S_LOADW: if (wload_done) state_d = S_HDR;
            S_HDR:   state_d = (hdr_term || hdr_bad) ? S_DRAIN : S_CONV;
            S_CONV:  if (last_row && last_k) state_d = S_HDR;
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        start   = 1'b0;
        ld_en   = 1'b0;
        hdr_en  = 1'b0;
        conv_en = 1'b0;
        busy_d  = state_d != S_IDLE;
        unique case (state_q)
            S_IDLE:  start   = dut_run;
            S_LOADW: ld_en   = 1'b1;
            S_HDR:   hdr_en  = 1'b1;
            S_CONV:  conv_en = 1'b1;
            default: ;
        endcase
    end

    // Zero-extend window rows so column offsets past the top bit read 0.
    always_comb begin
        for (int r = 0; r < 3; r++) win_ext[r] = {2'b00, win_q[r]};
    end

    always_comb begin
        conv_row = '0;
        match    = '0;
        for (int c = 0; c < DATA_W; c++) begin
            match = '0;
            for (int r = 0; r < 3; r++) begin
                for (int o = 0; o < 3; o++) begin
                    match = match +
                        {3'b000, ~(win_w_q[3*r+o] ^ win_ext[r][c+o])};
                end
            end
            conv_row[c] = (match >= win_t_q) && (c + 2 < int'(win_n_q));
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            k_q       <= '0;
            n_q       <= '0;
            base_q    <= '0;
            rd_addr_q <= '0;
            wm_addr_q <= '0;
            ptr_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            win_vld_q <= 1'b0;
            win_w_q   <= '0;
            win_t_q   <= '0;
            win_n_q   <= '0;
            for (int i = 0; i < NUM_KERNELS; i++) begin
                kern_w_q[i] <= '0;
                kern_t_q[i] <= '0;
            end
            for (int r = 0; r < 3; r++) win_q[r] <= '0;
        end else begin
            busy_q    <= busy_d;
            win_vld_q <= conv_en && (cnt_q >= CW'(2));
            wr_en_q   <= win_vld_q;
            if (win_vld_q) begin
                wr_data_q <= conv_row;
                wr_addr_q <= ptr_q;
                ptr_q     <= ptr_q + ADDR_W'(1);
            end
            if (start) begin
                err_q     <= 1'b0;
                base_q    <= '0;
                rd_addr_q <= '0;
                ptr_q     <= '0;
                wm_addr_q <= ADDR_W'(1);
                cnt_q     <= '0;
            end
            if (ld_en) begin
                wm_addr_q <= wm_addr_q + ADDR_W'(1);
                cnt_q     <= cnt_q + CW'(1);
                for (int i = 0; i < NUM_KERNELS; i++) begin
                    if (cnt_q == CW'(i + 1)) begin
                        kern_w_q[i] <= wmem_dut_read_data[8:0];
                        kern_t_q[i] <= ld_thr;
                    end
                end
                // Header address was presented during LOADW; prefetch row 1.
                if (wload_done) rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
            if (hdr_en) begin
                rd_addr_q <= rd_addr_q + ADDR_W'(1);
                k_q       <= '0;
                cnt_q     <= '0;
                if (!hdr_term && !hdr_bad) n_q <= sram_dut_read_data[NW-1:0];
                if (hdr_bad) err_q <= 1'b1;
            end
            if (conv_en) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= sram_dut_read_data;
                win_w_q  <= cur_w;
                win_t_q  <= cur_t;
                win_n_q  <= n_q;
                cnt_q    <= last_row ? '0 : cnt_q + CW'(1);
                // One row early, steer reads to the re-stream or next header
                // so consecutive passes run back to back.
                if (pre_last)
                    rd_addr_q <= last_k ? next_base : base_q + ADDR_W'(1);
                else
                    rd_addr_q <= rd_addr_q + ADDR_W'(1);
                if (last_row) begin
                    if (last_k) base_q <= next_base;
                    else        k_q    <= k_q + 4'd1;
                end
            end
        end
    end

endmodule
